// File: rtl/scope_trigger_ctrl_if.sv
// Sample stream into the trigger controller and the capture-buffer write port out of it.
// The slave side is the controller; the master side feeds samples and observes writes.
interface scope_trigger_ctrl_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output sample_valid, sample_data, input wr_en, wr_addr, wr_data);
  modport slave  (input sample_valid, sample_data, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/scope_trigger_ctrl.sv
// Oscilloscope trigger/capture controller: pre-trigger fill, edge or auto trigger, post fill, hold for display.
// Buffer writes are registered (1 cycle after the accepted sample); there is no backpressure, samples outside a capture are dropped.
module scope_trigger_ctrl #(
  parameter int DATA_W  = 14,
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10,
  parameter int PRE     = 160,
  parameter int AUTO_TO = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scope_trigger_ctrl_if.slave  smp,
  input  logic [DATA_W-1:0]    trig_level,
  input  logic                 trig_edge,
  input  logic [1:0]           trig_mode,
  input  logic                 arm,
  input  logic                 frame_done,
  output logic [ADDR_W-1:0]    start_addr,
  output logic [2:0]           state,
  output logic                 capture_done,
  output logic                 auto_fired
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRETRIG = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam int TO_W = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE);
  localparam logic [ADDR_W-1:0] WRAP_BACK = ADDR_W'(DEPTH - PRE);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] cand_q, cand_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic              capture_done_q, capture_done_d;
  logic              auto_fired_q, auto_fired_d;

  logic              accept;
  logic              cur_above;
  logic              prev_above;
  logic              edge_hit;
  logic              auto_hit;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] cand_addr;

  always_comb begin
    accept     = smp.sample_valid &&
                 (state_q == S_PRETRIG || state_q == S_WAIT || state_q == S_POST);
    cur_above  = smp.sample_data >= trig_level;
    prev_above = prev_q >= trig_level;
    edge_hit   = prev_vld_q && (trig_edge ? (prev_above && !cur_above)
                                          : (!prev_above && cur_above));
    auto_hit   = (trig_mode == 2'd0) && (to_cnt_q == TO_LAST);
    ptr_inc    = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    // Oldest displayed sample sits PRE slots behind the trigger, wrapping inside the buffer.
    cand_addr  = (ptr_q >= PRE_A) ? ptr_q - PRE_A : ptr_q + WRAP_BACK;
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    start_addr_d   = start_addr_q;
    cand_d         = cand_q;
    pre_cnt_d      = pre_cnt_q;
    post_cnt_d     = post_cnt_q;
    to_cnt_d       = to_cnt_q;
    prev_d         = prev_q;
    prev_vld_d     = prev_vld_q;
    capture_done_d = 1'b0;
    auto_fired_d   = 1'b0;

    if (accept) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = ptr_q;
      wr_data_d  = smp.sample_data;
      ptr_d      = ptr_inc;
      prev_d     = smp.sample_data;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_PRETRIG;
          pre_cnt_d  = '0;
          prev_vld_d = 1'b0;
        end
      end
      S_PRETRIG: begin
        if (accept) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q == PRE_LAST) begin
            state_d  = S_WAIT;
            to_cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (accept) begin
          // Saturates so a late switch to auto mode fires on the next sample.
          if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
          if (edge_hit || auto_hit) begin
            state_d      = S_POST;
            post_cnt_d   = ADDR_W'(1);
            cand_d       = cand_addr;
            auto_fired_d = !edge_hit;
          end
        end
      end
      S_POST: begin
        if (accept) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_q == POST_LAST) begin
            state_d        = S_HOLD;
            capture_done_d = 1'b1;
            start_addr_d   = cand_q;
          end
        end
      end
      S_HOLD: begin
        if (frame_done) begin
          state_d    = (trig_mode == 2'd2) ? S_IDLE : S_PRETRIG;
          pre_cnt_d  = '0;
          prev_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      start_addr_q   <= '0;
      cand_q         <= '0;
      pre_cnt_q      <= '0;
      post_cnt_q     <= '0;
      to_cnt_q       <= '0;
      prev_q         <= '0;
      prev_vld_q     <= 1'b0;
      capture_done_q <= 1'b0;
      auto_fired_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      start_addr_q   <= start_addr_d;
      cand_q         <= cand_d;
      pre_cnt_q      <= pre_cnt_d;
      post_cnt_q     <= post_cnt_d;
      to_cnt_q       <= to_cnt_d;
      prev_q         <= prev_d;
      prev_vld_q     <= prev_vld_d;
      capture_done_q <= capture_done_d;
      auto_fired_q   <= auto_fired_d;
    end
  end

  assign smp.wr_en     = wr_en_q;
  assign smp.wr_addr   = wr_addr_q;
  assign smp.wr_data   = wr_data_q;
  assign start_addr    = start_addr_q;
  assign state         = state_q;
  assign capture_done  = capture_done_q;
  assign auto_fired    = auto_fired_q;
endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Directed bench for scope_trigger_ctrl: normal, auto, single, pointer wrap, PRETRIG-only crossing, falling edge, reset abort.
module tb_scope_trigger_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [13:0] trig_level = 14'd8192;
  logic       trig_edge = 1'b0;
  logic [1:0] trig_mode = 2'd1;
  logic       arm = 1'b0;
  logic       frame_done = 1'b0;
  logic [9:0] start_addr;
  logic [2:0] state;
  logic       capture_done;
  logic       auto_fired;

  int n_checks = 0;
  int n_err    = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int auto_cnt = 0;
  int exp_ptr  = 0;
  int last_addr = 0;
  int saved_cnt;
  logic [13:0] mem [0:1023];

  scope_trigger_ctrl_if #(.DATA_W(14), .ADDR_W(10)) sif ();

  scope_trigger_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .smp          (sif),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .trig_mode    (trig_mode),
    .arm          (arm),
    .frame_done   (frame_done),
    .start_addr   (start_addr),
    .state        (state),
    .capture_done (capture_done),
    .auto_fired   (auto_fired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Write-port monitor: every write must land at the next circular address.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ptr = 0;
    end else begin
      if (sif.wr_en) begin
        check("wr_addr_seq", 32'(sif.wr_addr), 32'(exp_ptr));
        mem[sif.wr_addr] = sif.wr_data;
        last_addr = 32'(sif.wr_addr);
        wr_cnt++;
        exp_ptr = (exp_ptr == 639) ? 0 : exp_ptr + 1;
      end
      if (capture_done) done_cnt++;
      if (auto_fired) auto_cnt++;
    end
  end

  task automatic send(input logic [13:0] d);
    @(negedge clk);
    sif.sample_valid = 1'b1;
    sif.sample_data  = d;
    @(negedge clk);
    sif.sample_valid = 1'b0;
    #1;
  endtask

  task automatic send_n(input int n, input logic [13:0] d);
    for (int k = 0; k < n; k++) send(d);
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    #1;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    #1;
  endtask

  initial begin
    logic [13:0] v;
    sif.sample_valid = 1'b0;
    sif.sample_data  = '0;

    // Reset values while held in reset
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_wr_en", 32'(sif.wr_en), 32'd0);
    check("rst_wr_addr", 32'(sif.wr_addr), 32'd0);
    check("rst_wr_data", 32'(sif.wr_data), 32'd0);
    check("rst_start", 32'(start_addr), 32'd0);
    check("rst_done", 32'(capture_done), 32'd0);
    check("rst_auto", 32'(auto_fired), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal mode, rising ramp phased so the first post-PRETRIG sample hits 8192
    send(14'd77);
    check("idle_no_write", 32'(wr_cnt), 32'd0);
    pulse_arm();
    check("armed_pretrig", 32'(state), 32'd1);
    for (int i = 0; i < 160; i++) begin
      v = 14'((14336 + i * 64) % 16384);
      send(v);
    end
    check("pre_done_wait", 32'(state), 32'd2);
    check("pre_writes", 32'(wr_cnt), 32'd160);
    send(14'd8192);
    check("trig_post", 32'(state), 32'd3);
    for (int i = 161; i < 640; i++) begin
      v = 14'((14336 + i * 64) % 16384);
      send(v);
    end
    check("n_hold", 32'(state), 32'd4);
    check("n_writes", 32'(wr_cnt), 32'd640);
    check("n_done_once", 32'(done_cnt), 32'd1);
    check("n_start", 32'(start_addr), 32'd0);
    check("n_trig_data", 32'(mem[160]), 32'd8192);
    check("n_first_data", 32'(mem[0]), 32'd14336);
    send(14'd9);
    check("hold_no_write", 32'(wr_cnt), 32'd640);
    pulse_arm();
    check("hold_arm_ign", 32'(state), 32'd4);

    // Auto mode re-arm with a simultaneous sample: sample dropped, transition taken
    trig_mode = 2'd0;
    @(negedge clk);
    sif.sample_valid = 1'b1;
    sif.sample_data  = 14'd5;
    frame_done = 1'b1;
    @(negedge clk);
    sif.sample_valid = 1'b0;
    frame_done = 1'b0;
    #1;
    check("rearm_pretrig", 32'(state), 32'd1);
    check("rearm_no_write", 32'(wr_cnt), 32'd640);
    send_n(160 + 4095, 14'd100);
    check("auto_wait", 32'(state), 32'd2);
    check("auto_not_yet", 32'(auto_cnt), 32'd0);
    pulse_frame();
    check("wait_frame_ign", 32'(state), 32'd2);
    send(14'd100);
    check("auto_post", 32'(state), 32'd3);
    check("auto_fired", 32'(auto_cnt), 32'd1);
    send_n(479, 14'd100);
    check("auto_hold", 32'(state), 32'd4);
    check("auto_start", 32'(start_addr), 32'd255);
    check("auto_done", 32'(done_cnt), 32'd2);
    check("auto_writes", 32'(wr_cnt), 32'd5375);

    // Single mode: start address wraps below zero, then frame_done parks in IDLE
    trig_mode = 2'd2;
    pulse_frame();
    check("single_idle", 32'(state), 32'd0);
    pulse_arm();
    send_n(160 + 345, 14'd100);
    check("single_wait", 32'(state), 32'd2);
    send(14'd9000);
    check("single_post", 32'(state), 32'd3);
    send_n(479, 14'd9000);
    check("single_hold", 32'(state), 32'd4);
    check("single_start", 32'(start_addr), 32'd600);
    check("single_trig_d", 32'(mem[120]), 32'd9000);
    pulse_frame();
    check("single_end_idle", 32'(state), 32'd0);
    saved_cnt = wr_cnt;
    pulse_frame();
    send_n(3, 14'd9000);
    check("single_no_write", 32'(wr_cnt), 32'(saved_cnt));
    check("single_stay_idle", 32'(state), 32'd0);

    // Pointer wrap from 600 and a crossing that only occurs during PRETRIG
    trig_mode = 2'd1;
    pulse_arm();
    send_n(40, 14'd0);
    check("wrap_639", 32'(last_addr), 32'd639);
    send(14'd0);
    check("wrap_0", 32'(last_addr), 32'd0);
    send_n(39, 14'd0);
    send_n(80, 14'd9000);
    check("pre_cross_wait", 32'(state), 32'd2);
    send_n(200, 14'd9000);
    check("flat_stay_wait", 32'(state), 32'd2);
    check("flat_no_done", 32'(done_cnt), 32'd3);

    // Falling edge trigger, then reset in POST
    trig_edge = 1'b1;
    send(14'd100);
    check("fall_post", 32'(state), 32'd3);
    check("post_start_keep", 32'(start_addr), 32'd600);
    send_n(10, 14'd100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_wr_en", 32'(sif.wr_en), 32'd0);
    check("abort_wr_addr", 32'(sif.wr_addr), 32'd0);
    check("abort_wr_data", 32'(sif.wr_data), 32'd0);
    check("abort_start", 32'(start_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saved_cnt = wr_cnt;
    send_n(5, 14'd50);
    check("abort_no_write", 32'(wr_cnt), 32'(saved_cnt));
    check("abort_idle", 32'(state), 32'd0);
    check("abort_done_cnt", 32'(done_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/scope_trigger_ctrl.md
SCOPE_TRIGGER_CTRL -- requirements
Module: scope_trigger_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 14, sample width; DEPTH, default 640, capture buffer length (one sample per screen column); ADDR_W, default 10, buffer address width; PRE, default 160, pre-trigger samples; AUTO_TO, default 4096, auto-mode timeout in accepted samples.
REQ-002 SHALL have ports: clock  in  1  single system clock, all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 sample_valid  in  1  one-cycle strobe marking a new ADC/test-wave sample.
REQ-005 sample_data  in  DATA_W  unsigned sample, valid with sample_valid.
REQ-006 trig_level  in  DATA_W  unsigned trigger threshold.
REQ-007 trig_edge  in  1  0 = rising, 1 = falling.
REQ-008 trig_mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = treated as normal.
REQ-009 arm  in  1  one-cycle pulse starting an acquisition from IDLE.
REQ-010 frame_done  in  1  one-cycle pulse from the display path (end of vsync frame) releasing the buffer.
REQ-011 wr_en  out  1; wr_addr  out  ADDR_W; wr_data  out  DATA_W  capture buffer write port.
REQ-012 start_addr  out  ADDR_W  address of oldest sample of the last completed capture (display column 0).
REQ-013 state  out  3  IDLE=0, PRETRIG=1, WAIT_TRIG=2, POST=3, HOLD=4.
REQ-014 capture_done  out  1  one-cycle pulse on entry to HOLD; auto_fired  out  1  one-cycle pulse when auto timeout forces a trigger.

Function
REQ-015 Every accepted sample (sample_valid=1 in PRETRIG, WAIT_TRIG or POST) SHALL produce wr_en=1 in the next cycle with wr_data = sample, wr_addr = write pointer; pointer then increments, wrapping DEPTH-1 -> 0 (latency 1 cycle, registered outputs).
REQ-016 Samples in IDLE and HOLD SHALL be ignored: no write, no pointer change, no counter change.
REQ-017 IDLE -> PRETRIG on arm; pre-counter cleared, edge history invalidated; write pointer not reset (buffer is circular).
REQ-018 PRETRIG -> WAIT_TRIG when PRE samples have been written.
REQ-019 Trigger condition on an accepted sample: rising: prev < trig_level and cur >= trig_level; falling: prev >= trig_level and cur < trig_level; prev = previous accepted sample; no trigger on the first sample after arm (history invalid).
REQ-020 Edge history SHALL be updated in PRETRIG too, but a condition met in PRETRIG SHALL NOT trigger.
REQ-021 WAIT_TRIG -> POST on trigger sample; the trigger sample is written and counts as post sample 1; start_addr candidate = trigger address minus PRE, modulo DEPTH.
REQ-022 Auto mode: timeout counter counts accepted samples in WAIT_TRIG; at AUTO_TO without trigger, the AUTO_TO-th sample is treated as trigger and auto_fired pulses; counter clears on entry to WAIT_TRIG.
REQ-023 POST -> HOLD when DEPTH-PRE post samples written (total DEPTH samples since arm); start_addr updated from candidate in the same cycle capture_done pulses.
REQ-024 HOLD: on frame_done, mode auto/normal -> PRETRIG (re-arm automatically); mode single -> IDLE.
REQ-025 arm outside IDLE SHALL be ignored; frame_done outside HOLD SHALL be ignored.
REQ-026 Simultaneous sample_valid and frame_done in HOLD: sample ignored, transition taken.
REQ-027 trig_mode, trig_edge, trig_level sampled live each accepted sample; mode change mid-capture takes effect at the next decision point.
REQ-028 All arithmetic on unsigned DATA_W values; address subtraction wraps within 0..DEPTH-1 (not 2^ADDR_W).

Reset
REQ-029 On reset low, immediately: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, start_addr=0, capture_done=0, auto_fired=0, all counters and edge history cleared.
REQ-030 Reset asserted mid-capture SHALL abort with no further writes; after release the block waits in IDLE for arm.

Verification
REQ-031 Normal mode, level 8192, rising ramp 0..16383 step 64, arm -> 160 writes, trigger at first sample >= 8192 after PRETRIG, exactly 640 writes total, capture_done once, start_addr = trig addr - 160 mod 640.
REQ-032 Auto mode, constant input 100, level 8192 -> auto_fired after 4096 WAIT_TRIG samples, capture completes, HOLD.
REQ-033 Single mode, capture completes, frame_done -> state IDLE; second frame_done and samples -> no writes.
REQ-034 Pointer wrap: arm with wr_addr=600 -> writes continue 639 -> 0; start_addr computed modulo 640.
REQ-035 Crossing during PRETRIG only, then flat -> no trigger in normal mode, state stays WAIT_TRIG.
REQ-036 Reset pulse during POST -> all outputs at reset values, wr_en stays 0 until arm.
